// File: rtl/coef_dump_pkg.sv
// coef_dump_pkg: shared FSM encoding and sizing helpers for coef_dump_engine.
// The optional checksum output is enabled by defining COEF_DUMP_CHECKSUM_EN.
package coef_dump_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_FIN   = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      DRAIN = ST_DRAIN,
      FIN   = ST_FIN
   } state_t;

   // Checksum lane width; DATA_W must be a multiple of this when the checksum is built.
   localparam int LANE_W = 32;

   // Ceiling log2 that never returns less than 1, so index vectors stay legal for 1 entry.
   function automatic int clog2_min1(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/coef_dump_if.sv
// coef_dump_if: request/handshake and RAM read-port bundle for coef_dump_engine.
// With COEF_DUMP_CHECKSUM_EN defined the bundle also carries dump_chk.
//
// Handshake: start is only looked at while the engine is idle; a high start in
// an idle cycle is taken immediately (no ready signal, nothing is queued). busy
// is high from the next cycle until the dump completes, and done pulses for
// exactly one cycle with busy low, at which point ntt_debug is final and held.
interface coef_dump_if #(
   parameter int DATA_W    = 3072,
   parameter int ADDR_W    = 8,
   parameter int NUM_WORDS = 2,
   parameter int CNT_W     = 8
);
   import coef_dump_pkg::*;

   logic                          start;
   logic [ADDR_W-1:0]             start_ad;
   logic [CNT_W-1:0]              len;
   logic [DATA_W-1:0]             Coef_RData;
   logic [ADDR_W-1:0]             Coef_RAd;
   logic [NUM_WORDS*DATA_W-1:0]   ntt_debug;
   logic                          busy;
   logic                          done;
   state_t                        state;
`ifdef COEF_DUMP_CHECKSUM_EN
   logic [31:0]                   dump_chk;
`endif

`ifdef COEF_DUMP_CHECKSUM_EN
   modport master (
      output start, start_ad, len, Coef_RData,
      input  Coef_RAd, ntt_debug, busy, done, state, dump_chk
   );
   modport slave (
      input  start, start_ad, len, Coef_RData,
      output Coef_RAd, ntt_debug, busy, done, state, dump_chk
   );
`else
   modport master (
      output start, start_ad, len, Coef_RData,
      input  Coef_RAd, ntt_debug, busy, done, state
   );
   modport slave (
      input  start, start_ad, len, Coef_RData,
      output Coef_RAd, ntt_debug, busy, done, state
   );
`endif

endinterface

// File: rtl/coef_dump_lat_pipe.sv
// coef_dump_lat_pipe: DEPTH-stage {valid, slot index} delay line that lines a
// capture strobe up with RAM read data returning DEPTH cycles after the address.
module coef_dump_lat_pipe #(
   parameter int DEPTH = 1,
   parameter int IDX_W = 1
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             in_valid_i,
   input  logic [IDX_W-1:0] in_idx_i,
   output logic             cap_valid_o,
   output logic [IDX_W-1:0] cap_idx_o,
   output logic             more_o
);

   logic [DEPTH-1:0] valid_q;
   logic [IDX_W-1:0] idx_q [DEPTH];

   // Shift the issue marker one stage per cycle; clear drops every pending entry.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
      end else begin
         valid_q[0] <= in_valid_i;
         idx_q[0]   <= in_idx_i;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            idx_q[i]   <= idx_q[i-1];
         end
      end
   end

   assign cap_valid_o = valid_q[DEPTH-1];
   assign cap_idx_o   = idx_q[DEPTH-1];

   // Entries still queued behind the output stage; low means the line is empty after this edge.
   always_comb begin
      more_o = 1'b0;
      for (int i = 0; i < DEPTH - 1; i++) more_o = more_o | valid_q[i];
   end

endmodule

// File: rtl/coef_dump_engine.sv
// coef_dump_engine: reads up to NUM_WORDS consecutive coefficient RAM words from
// a programmable address, tolerating RD_LAT cycles of read latency, and packs
// them MSB-first into ntt_debug. Define COEF_DUMP_CHECKSUM_EN to add dump_chk.
module coef_dump_engine
   import coef_dump_pkg::*;
#(
   parameter int DATA_W    = 3072,
   parameter int ADDR_W    = 8,
   parameter int NUM_WORDS = 2,
   parameter int RD_LAT    = 1,
   parameter int CNT_W     = 8
) (
   input logic        clk,
   input logic        reset_n,
   coef_dump_if.slave bus
);

   localparam int          IDX_W = clog2_min1(NUM_WORDS);
   localparam logic [31:0] NW_U  = NUM_WORDS;

   state_t              state_q;
   logic [ADDR_W-1:0]   rad_q;
   logic                busy_q;
   logic                done_q;
   logic [CNT_W-1:0]    len_q;
   logic [IDX_W-1:0]    issue_cnt_q;
   logic [DATA_W-1:0]   slot_q [NUM_WORDS];
   logic [CNT_W-1:0]    eff_len_d;
   logic                accept_d;
   logic                cap_valid;
   logic [IDX_W-1:0]    cap_idx;
   logic                pipe_more;
   logic [NUM_WORDS*DATA_W-1:0] dbg_flat_d;

   // Requested length clamped to the number of slots.
   always_comb begin
      if (32'(bus.len) > NW_U) eff_len_d = CNT_W'(NUM_WORDS);
      else                     eff_len_d = bus.len;
   end

   assign accept_d = (state_q == IDLE) && bus.start;

   // Control FSM: address issue, drain wait and the registered busy/done/address outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rad_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         len_q       <= '0;
         issue_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  len_q       <= eff_len_d;
                  issue_cnt_q <= '0;
                  if (eff_len_d == '0) begin
                     // Nothing to read: the address is left alone and done follows at once.
                     state_q <= FIN;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ISSUE;
                     rad_q   <= bus.start_ad;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if ((32'(issue_cnt_q) + 32'd1) == 32'(len_q)) begin
                  // Last address stays on the bus while the reads drain.
                  state_q <= DRAIN;
               end else begin
                  issue_cnt_q <= issue_cnt_q + IDX_W'(1);
                  rad_q       <= rad_q + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (!pipe_more) begin
                  state_q <= FIN;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            FIN: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   coef_dump_lat_pipe #(
      .DEPTH (RD_LAT),
      .IDX_W (IDX_W)
   ) u_lat_pipe (
      .clk         (clk),
      .clr_n       (reset_n),
      .in_valid_i  (state_q == ISSUE),
      .in_idx_i    (issue_cnt_q),
      .cap_valid_o (cap_valid),
      .cap_idx_o   (cap_idx),
      .more_o      (pipe_more)
   );

   // Slot storage: wiped on a new request, filled by the delayed capture strobe.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_WORDS; k++) slot_q[k] <= '0;
      end else if (accept_d) begin
         for (int k = 0; k < NUM_WORDS; k++) slot_q[k] <= '0;
      end else if (cap_valid) begin
         slot_q[cap_idx] <= bus.Coef_RData;
      end
   end

   // Word k lands at the k-th position counting down from the MSB end.
   always_comb begin
      dbg_flat_d = '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         dbg_flat_d[(NUM_WORDS - k) * DATA_W - 1 -: DATA_W] = slot_q[k];
      end
   end

   assign bus.ntt_debug = dbg_flat_d;
   assign bus.Coef_RAd  = rad_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.state     = state_q;

`ifdef COEF_DUMP_CHECKSUM_EN
   logic [LANE_W-1:0] chk_q;
   logic [LANE_W-1:0] lane_x_d;

   // XOR of all 32-bit lanes of the word being returned this cycle.
   always_comb begin
      lane_x_d = '0;
      for (int i = 0; i < DATA_W / LANE_W; i++) lane_x_d = lane_x_d ^ bus.Coef_RData[i * LANE_W +: LANE_W];
   end

   // Running checksum over captured words, restarted with each accepted request.
   always_ff @(posedge clk) begin
      if (!reset_n)       chk_q <= '0;
      else if (accept_d)  chk_q <= '0;
      else if (cap_valid) chk_q <= chk_q ^ lane_x_d;
   end

   assign bus.dump_chk = chk_q;
`endif

endmodule

// File: tb/tb_coef_dump_engine.sv
// tb_coef_dump_engine: two engine instances (2 words / latency 1 at full width,
// 4 words / latency 3 at 128 bits) driven by directed and random dumps and
// compared against a cycle-level reference computed from the dump rules.
module tb_coef_dump_engine;
   import coef_dump_pkg::*;

   localparam int DWA = 3072, NWA = 2, LATA = 1;
   localparam int DWB = 128,  NWB = 4, LATB = 3;
   localparam int AW = 8, CW = 8;
   localparam int WIDE = NWA * DWA;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_a_n, rst_b_n;

   coef_dump_if #(.DATA_W(DWA), .ADDR_W(AW), .NUM_WORDS(NWA), .CNT_W(CW)) ifa ();
   coef_dump_if #(.DATA_W(DWB), .ADDR_W(AW), .NUM_WORDS(NWB), .CNT_W(CW)) ifb ();

   coef_dump_engine #(.DATA_W(DWA), .ADDR_W(AW), .NUM_WORDS(NWA), .RD_LAT(LATA), .CNT_W(CW))
      dut_a (.clk(clk), .reset_n(rst_a_n), .bus(ifa));
   coef_dump_engine #(.DATA_W(DWB), .ADDR_W(AW), .NUM_WORDS(NWB), .RD_LAT(LATB), .CNT_W(CW))
      dut_b (.clk(clk), .reset_n(rst_b_n), .bus(ifb));

   // ---------------- RAM model with read latency ----------------
   logic [DWA-1:0] mem [256];
   logic [AW-1:0]  ahist_a [LATA];
   logic [AW-1:0]  ahist_b [LATB];

   always @(posedge clk) begin
      ahist_a[0] <= ifa.Coef_RAd;
      for (int i = 1; i < LATA; i++) ahist_a[i] <= ahist_a[i-1];
      ahist_b[0] <= ifb.Coef_RAd;
      for (int i = 1; i < LATB; i++) ahist_b[i] <= ahist_b[i-1];
   end

   assign ifa.Coef_RData = mem[ahist_a[LATA-1]];
   assign ifb.Coef_RData = mem[ahist_b[LATB-1]][DWB-1:0];

   // ---------------- scoreboard counters / checks ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wide(input string tag, input logic [WIDE-1:0] obs, input logic [WIDE-1:0] exp);
      int li;
      li = 0;
      for (int i = WIDE / 32 - 1; i >= 0; i--) begin
         if (obs[i*32 +: 32] !== exp[i*32 +: 32]) li = i;
      end
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: lane %0d observed %h expected %h", tag, li, obs[li*32 +: 32], exp[li*32 +: 32]);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [WIDE-1:0] model_dbg(input int sel, input logic [7:0] ad, input int len_eff);
      int nw, dw;
      logic [WIDE-1:0] r, w, mask;
      nw = (sel == 0) ? NWA : NWB;
      dw = (sel == 0) ? DWA : DWB;
      mask = {WIDE{1'b1}} >> (WIDE - dw);
      r = '0;
      for (int k = 0; k < len_eff; k++) begin
         w = WIDE'(mem[8'(ad + k)]) & mask;
         r = r | (w << ((nw - 1 - k) * dw));
      end
      return r;
   endfunction

`ifdef COEF_DUMP_CHECKSUM_EN
   function automatic logic [31:0] model_chk(input int sel, input logic [7:0] ad, input int len_eff);
      int dw;
      logic [31:0] c;
      dw = (sel == 0) ? DWA : DWB;
      c = '0;
      for (int k = 0; k < len_eff; k++)
         for (int j = 0; j < dw / 32; j++) c = c ^ mem[8'(ad + k)][j*32 +: 32];
      return c;
   endfunction
   logic [31:0] o_chk;
`endif

   // ---------------- driver / sampler tasks ----------------
   logic [7:0]      o_rad;
   logic            o_busy, o_done;
   logic [1:0]      o_state;
   logic [WIDE-1:0] o_dbg;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) ifa.start = v;
      else          ifb.start = v;
   endtask

   task automatic drive(input int sel, input logic st, input logic [7:0] ad, input logic [7:0] ln);
      if (sel == 0) begin
         ifa.start = st; ifa.start_ad = ad; ifa.len = ln;
      end else begin
         ifb.start = st; ifb.start_ad = ad; ifb.len = ln;
      end
   endtask

   task automatic sample(input int sel);
      if (sel == 0) begin
         o_rad = ifa.Coef_RAd; o_busy = ifa.busy; o_done = ifa.done;
         o_state = ifa.state; o_dbg = WIDE'(ifa.ntt_debug);
`ifdef COEF_DUMP_CHECKSUM_EN
         o_chk = ifa.dump_chk;
`endif
      end else begin
         o_rad = ifb.Coef_RAd; o_busy = ifb.busy; o_done = ifb.done;
         o_state = ifb.state; o_dbg = WIDE'(ifb.ntt_debug);
`ifdef COEF_DUMP_CHECKSUM_EN
         o_chk = ifb.dump_chk;
`endif
      end
   endtask

   // One dump, accepted in the current cycle T; checks every cycle up to done+1.
   task automatic run_dump(input int sel, input logic [7:0] ad, input int ln, input bit hold, input bit repulse);
      int nw, lat, len_eff, done_at;
      logic [7:0] rad0, exp_rad;
      logic [WIDE-1:0] exp_dbg;
      nw = (sel == 0) ? NWA : NWB;
      lat = (sel == 0) ? LATA : LATB;
      len_eff = (ln > nw) ? nw : ln;
      done_at = (len_eff == 0) ? 1 : len_eff + lat + 1;
      exp_dbg = model_dbg(sel, ad, len_eff);
      sample(sel);
      rad0 = o_rad;
      drive(sel, 1'b1, ad, 8'(ln));
      for (int j = 1; j <= done_at + 1; j++) begin
         tick();
         if (!hold && j == 1) set_start(sel, 1'b0);
         if (repulse && j == 2) set_start(sel, 1'b1);
         if (repulse && j == 3) set_start(sel, 1'b0);
         sample(sel);
         if (len_eff == 0)      exp_rad = rad0;
         else if (j <= len_eff) exp_rad = 8'(ad + j - 1);
         else                   exp_rad = 8'(ad + len_eff - 1);
         chk("rad", 64'(o_rad), 64'(exp_rad));
         chk("busy", 64'(o_busy), 64'(j < done_at));
         chk("done", 64'(o_done), 64'(j == done_at));
         if (j == 1 && done_at > 1) begin
            chk_wide("dbg_clear", o_dbg, '0);
`ifdef COEF_DUMP_CHECKSUM_EN
            chk("chk_clear", 64'(o_chk), 64'd0);
`endif
         end
         if (j >= done_at) chk_wide("dbg", o_dbg, exp_dbg);
         if (j == done_at) begin
            chk("state_fin", 64'(o_state), 64'(FIN));
`ifdef COEF_DUMP_CHECKSUM_EN
            chk("chk", 64'(o_chk), 64'(model_chk(sel, ad, len_eff)));
`endif
         end
         if (j == done_at + 1) chk("state_idle", 64'(o_state), 64'(IDLE));
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int sel, nw, ln;
      logic [7:0] ad;
      for (int a = 0; a < 256; a++) begin
         for (int j = 0; j < DWA / 32; j++) mem[a][j*32 +: 32] = $urandom;
         mem[a][7:0] = 8'(a);
      end
      drive(0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 8'h00, 8'h00);
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      repeat (3) tick();
      for (int s = 0; s < 2; s++) begin
         sample(s);
         chk("rst_rad", 64'(o_rad), 64'd0);
         chk("rst_busy", 64'(o_busy), 64'd0);
         chk("rst_done", 64'(o_done), 64'd0);
         chk("rst_state", 64'(o_state), 64'(IDLE));
         chk_wide("rst_dbg", o_dbg, '0);
`ifdef COEF_DUMP_CHECKSUM_EN
         chk("rst_chk", 64'(o_chk), 64'd0);
`endif
      end
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;
      tick();

      // Basic two-word dump with explicit slot placement.
      run_dump(0, 8'h10, 2, 0, 0);
      chk_wide("slot0", WIDE'(ifa.ntt_debug[6143:3072]), WIDE'(mem[8'h10]));
      chk_wide("slot1", WIDE'(ifa.ntt_debug[3071:0]), WIDE'(mem[8'h11]));

      // Address wrap with latency 3, zero length, clamped length.
      run_dump(1, 8'hFE, 4, 0, 0);
      run_dump(0, 8'h33, 0, 0, 0);
      run_dump(1, 8'h40, 9, 0, 0);

      // Start re-pulsed during issue, then start held across two dumps.
      run_dump(0, 8'h50, 2, 0, 1);
      run_dump(0, 8'h60, 2, 1, 0);
      run_dump(0, 8'h70, 2, 0, 0);

      // Reset in cycle T+2 of a dump aborts it cleanly.
      drive(0, 1'b1, 8'h10, 8'd2);
      tick();
      set_start(0, 1'b0);
      tick();
      rst_a_n = 1'b0;
      tick();
      sample(0);
      chk("abort_rad", 64'(o_rad), 64'd0);
      chk("abort_busy", 64'(o_busy), 64'd0);
      chk("abort_done", 64'(o_done), 64'd0);
      chk("abort_state", 64'(o_state), 64'(IDLE));
      chk_wide("abort_dbg", o_dbg, '0);
      rst_a_n = 1'b1;
      tick();
      sample(0);
      chk("abort_no_done", 64'(o_done), 64'd0);
      run_dump(0, 8'h90, 2, 0, 0);

      // Lane patterns whose checksums cancel.
      for (int j = 0; j < DWA / 32; j++) begin
         mem[8'h20][j*32 +: 32] = 32'hA5A5A5A5;
         mem[8'h21][j*32 +: 32] = 32'h5A5A5A5A;
         mem[8'h30][j*32 +: 32] = 32'h00000001;
      end
      run_dump(0, 8'h20, 2, 0, 0);
`ifdef COEF_DUMP_CHECKSUM_EN
      chk("chk_a5_5a", 64'(o_chk), 64'd0);
`endif
      run_dump(0, 8'h30, 1, 0, 0);
`ifdef COEF_DUMP_CHECKSUM_EN
      chk("chk_ones", 64'(o_chk), 64'd0);
`endif

      // Random dumps on either instance.
      for (int n = 0; n < 12; n++) begin
         sel = int'($urandom_range(0, 1));
         nw = (sel == 0) ? NWA : NWB;
         ad = 8'($urandom_range(0, 255));
         ln = int'($urandom_range(0, nw + 3));
         run_dump(sel, ad, ln, 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
